// File: rtl/encoder_controller_if.sv
// encoder_controller_if: strobe/index bundle between encoder_controller and its datapath. Rev 1.0
`default_nettype none

interface encoder_controller_if #(
  parameter int DIM  = 5,
  parameter int LANE = 64
);
  localparam int IW = (DIM  > 1) ? $clog2(DIM)  : 1;
  localparam int KW = (LANE > 1) ? $clog2(LANE) : 1;

  logic          start;
  logic          reset;
  logic          read;
  logic          resetk;
  logic          inc;
  logic          write;
  logic          incij;
  logic [IW-1:0] i_idx;
  logic [IW-1:0] j_idx;
  logic [KW-1:0] k_idx;
  logic          busy;
  logic          done;

  modport master (
    input  start,
    output reset, read, resetk, inc, write, incij, i_idx, j_idx, k_idx, busy, done
  );

  modport slave (
    output start,
    input  reset, read, resetk, inc, write, incij, i_idx, j_idx, k_idx, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/encoder_controller.sv
// encoder_controller: Moore FSM sweeping a DIM x DIM grid of LANE-bit cells, row-major. Rev 1.0
`default_nettype none

module encoder_controller #(
  parameter int DIM  = 5,
  parameter int LANE = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  encoder_controller_if.master bus
);
  localparam int IW = (DIM  > 1) ? $clog2(DIM)  : 1;
  localparam int KW = (LANE > 1) ? $clog2(LANE) : 1;
  localparam logic [IW-1:0] c_IJ_LAST = IW'(DIM - 1);
  localparam logic [KW-1:0] c_K_LAST  = KW'(LANE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_RESETK = 3'd2,
    S_CELL   = 3'd3,
    S_WRITE  = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic          w_reset;
  logic          w_read;
  logic          w_resetk;
  logic          w_inc;
  logic          w_write;
  logic          w_incij;
  logic          w_busy;
  logic          w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes depend on r_state only; start affects nothing but the IDLE exit.
  always_comb begin
    w_next   = r_state;
    w_reset  = 1'b0;
    w_read   = 1'b0;
    w_resetk = 1'b0;
    w_inc    = 1'b0;
    w_write  = 1'b0;
    w_incij  = 1'b0;
    w_done   = 1'b0;
    w_busy   = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_INIT;
      end
      S_INIT: begin
        w_reset = 1'b1;
        w_read  = 1'b1;
        w_next  = S_RESETK;
      end
      S_RESETK: begin
        w_resetk = 1'b1;
        w_next   = S_CELL;
      end
      S_CELL: begin
        w_inc = 1'b1;
        if (r_k == c_K_LAST) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_write = 1'b1;
        if (r_i == c_IJ_LAST && r_j == c_IJ_LAST) w_next = S_DONE;
        else                                      w_next = S_NEXT;
      end
      S_NEXT: begin
        w_incij = 1'b1;
        w_next  = S_RESETK;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        S_RESETK: r_k <= '0;
        S_CELL: begin
          if (r_k != c_K_LAST) r_k <= r_k + KW'(1);
        end
        S_NEXT: begin
          if (r_j == c_IJ_LAST) begin
            r_j <= '0;
            r_i <= r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reset  = w_reset;
  assign bus.read   = w_read;
  assign bus.resetk = w_resetk;
  assign bus.inc    = w_inc;
  assign bus.write  = w_write;
  assign bus.incij  = w_incij;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.i_idx  = r_i;
  assign bus.j_idx  = r_j;
  assign bus.k_idx  = r_k;
endmodule

`default_nettype wire

// File: tb/tb_encoder_controller.sv
// tb_encoder_controller: directed checks of encoder_controller on a 2x2x4 and a 5x5x64 instance.
`default_nettype none

module tb_encoder_controller;
  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  always #5 clk = ~clk;

  encoder_controller_if #(.DIM(2), .LANE(4))  bus_s ();
  encoder_controller_if #(.DIM(5), .LANE(64)) bus_b ();

  encoder_controller #(.DIM(2), .LANE(4)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s.master)
  );

  encoder_controller #(.DIM(5), .LANE(64)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.master)
  );

  int tests = 0;
  int fails = 0;
  int n_reset, n_read, n_resetk, n_inc, n_write, n_incij;
  int n_done, done1, done2, n_overlap, k_err, k_exp, busy_err;
  int wr_i[$];
  int wr_j[$];

  task automatic clear_stats();
    n_reset = 0; n_read = 0; n_resetk = 0; n_inc = 0; n_write = 0; n_incij = 0;
    n_done = 0; done1 = -1; done2 = -1; n_overlap = 0; k_err = 0; k_exp = 0; busy_err = 0;
    wr_i.delete();
    wr_j.delete();
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) bus_b.start = v;
    else     bus_s.start = v;
  endtask

  // After this returns, the next negedge is cycle 1 after the start edge.
  task automatic start_pulse(input bit big);
    @(posedge clk);
    #1 set_start(big, 1'b1);
    @(posedge clk);
    #1 set_start(big, 1'b0);
  endtask

  task automatic collect(input bit big, input int first, input int ncyc);
    logic rs, rd, rk, in, wr, ij, bz, dn;
    int ii, jj, kk, act;
    for (int c = first; c < first + ncyc; c++) begin
      @(negedge clk);
      if (big) begin
        rs = bus_b.reset; rd = bus_b.read; rk = bus_b.resetk; in = bus_b.inc;
        wr = bus_b.write; ij = bus_b.incij; bz = bus_b.busy; dn = bus_b.done;
        ii = int'(bus_b.i_idx); jj = int'(bus_b.j_idx); kk = int'(bus_b.k_idx);
      end else begin
        rs = bus_s.reset; rd = bus_s.read; rk = bus_s.resetk; in = bus_s.inc;
        wr = bus_s.write; ij = bus_s.incij; bz = bus_s.busy; dn = bus_s.done;
        ii = int'(bus_s.i_idx); jj = int'(bus_s.j_idx); kk = int'(bus_s.k_idx);
      end
      act = int'(rs) + int'(rd) + int'(rk) + int'(in) + int'(wr) + int'(ij) + int'(dn);
      if (act > 1 && !(act == 2 && rs && rd)) n_overlap++;
      if (bz !== (act != 0)) busy_err++;
      n_reset += int'(rs); n_read += int'(rd); n_resetk += int'(rk);
      n_inc += int'(in); n_write += int'(wr); n_incij += int'(ij);
      if (rk) k_exp = 0;
      if (in) begin
        if (kk != k_exp) k_err++;
        k_exp++;
      end
      if (wr) begin
        wr_i.push_back(ii);
        wr_j.push_back(jj);
      end
      if (dn) begin
        n_done++;
        if (done1 < 0) done1 = c;
        else           done2 = c;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] s_out, b_out;
    rst_s = 1'b0; rst_b = 1'b0;
    bus_s.start = 1'b0; bus_b.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b1; rst_b = 1'b1;
    #1;
    s_out = {bus_s.reset, bus_s.read, bus_s.resetk, bus_s.inc, bus_s.write, bus_s.incij, bus_s.busy, bus_s.done};
    b_out = {bus_b.reset, bus_b.read, bus_b.resetk, bus_b.inc, bus_b.write, bus_b.incij, bus_b.busy, bus_b.done};
    tests++;
    if (s_out !== 8'h00) begin fails++; $display("FAIL reset_outputs_small: got %b expected 00000000", s_out); end
    tests++;
    if (b_out !== 8'h00) begin fails++; $display("FAIL reset_outputs_big: got %b expected 00000000", b_out); end
    tests++;
    if ({bus_b.i_idx, bus_b.j_idx, bus_b.k_idx} !== 12'h000) begin
      fails++; $display("FAIL reset_idx_big: got %h expected 000", {bus_b.i_idx, bus_b.j_idx, bus_b.k_idx});
    end
    clear_stats();
    collect(1'b1, 1, 5);
    tests++;
    if (n_reset + n_inc + n_resetk + busy_err != 0) begin
      fails++; $display("FAIL idle_after_reset: got activity %0d expected 0", n_reset + n_inc + n_resetk + busy_err);
    end
  endtask

  task automatic test_small_encode();
    int bad = 0;
    clear_stats();
    start_pulse(1'b0);
    collect(1'b0, 1, 40);
    tests++; if (done1 != 29) begin fails++; $display("FAIL small_done_cycle: got %0d expected 29", done1); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL small_done_count: got %0d expected 1", n_done); end
    tests++; if (n_inc != 16) begin fails++; $display("FAIL small_inc: got %0d expected 16", n_inc); end
    tests++; if (n_resetk != 4) begin fails++; $display("FAIL small_resetk: got %0d expected 4", n_resetk); end
    tests++; if (n_write != 4) begin fails++; $display("FAIL small_write: got %0d expected 4", n_write); end
    tests++; if (n_incij != 3) begin fails++; $display("FAIL small_incij: got %0d expected 3", n_incij); end
    tests++;
    if (n_reset != 1 || n_read != 1) begin
      fails++; $display("FAIL small_reset_read: got %0d/%0d expected 1/1", n_reset, n_read);
    end
    tests++;
    if (n_overlap != 0 || busy_err != 0 || k_err != 0) begin
      fails++; $display("FAIL small_strobe_rules: got overlap=%0d busy_err=%0d k_err=%0d expected 0", n_overlap, busy_err, k_err);
    end
    if (wr_i.size() != 4) bad++;
    else for (int n = 0; n < 4; n++) if (wr_i[n] != n / 2 || wr_j[n] != n % 2) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL small_write_order: got %0d bad entries expected 0", bad); end
  endtask

  task automatic test_full_encode();
    int bad = 0;
    clear_stats();
    start_pulse(1'b1);
    collect(1'b1, 1, 1700);
    tests++; if (done1 != 1676) begin fails++; $display("FAIL full_done_cycle: got %0d expected 1676", done1); end
    tests++; if (n_inc != 1600) begin fails++; $display("FAIL full_inc: got %0d expected 1600", n_inc); end
    tests++;
    if (n_write != 25 || n_incij != 24) begin
      fails++; $display("FAIL full_write_incij: got %0d/%0d expected 25/24", n_write, n_incij);
    end
    tests++; if (k_err != 0) begin fails++; $display("FAIL full_k_sequence: got %0d errors expected 0", k_err); end
    if (wr_i.size() != 25) bad++;
    else for (int n = 0; n < 25; n++) if (wr_i[n] != n / 5 || wr_j[n] != n % 5) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL full_write_order: got %0d bad entries expected 0", bad); end
  endtask

  task automatic test_start_while_busy();
    clear_stats();
    start_pulse(1'b1);
    collect(1'b1, 1, 9);
    set_start(1'b1, 1'b1);
    collect(1'b1, 10, 1);
    set_start(1'b1, 1'b0);
    collect(1'b1, 11, 489);
    set_start(1'b1, 1'b1);
    collect(1'b1, 500, 1);
    set_start(1'b1, 1'b0);
    collect(1'b1, 501, 1200);
    tests++;
    if (done1 != 1676 || n_done != 1) begin
      fails++; $display("FAIL busy_start_ignored: got done at %0d count %0d expected 1676 count 1", done1, n_done);
    end
  endtask

  task automatic test_reset_mid_encode();
    logic [7:0] b_out;
    clear_stats();
    start_pulse(1'b1);
    collect(1'b1, 1, 799);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    b_out = {bus_b.reset, bus_b.read, bus_b.resetk, bus_b.inc, bus_b.write, bus_b.incij, bus_b.busy, bus_b.done};
    tests++;
    if (b_out !== 8'h00 || {bus_b.i_idx, bus_b.j_idx, bus_b.k_idx} !== 12'h000) begin
      fails++; $display("FAIL midreset_outputs: got %b idx %h expected 00000000 idx 000", b_out, {bus_b.i_idx, bus_b.j_idx, bus_b.k_idx});
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    clear_stats();
    collect(1'b1, 1, 20);
    tests++;
    if (n_done != 0 || n_inc != 0) begin
      fails++; $display("FAIL midreset_abandoned: got done=%0d inc=%0d expected 0/0", n_done, n_inc);
    end
    clear_stats();
    start_pulse(1'b1);
    collect(1'b1, 1, 1700);
    tests++;
    if (done1 != 1676 || n_done != 1) begin
      fails++; $display("FAIL midreset_restart: got done at %0d count %0d expected 1676 count 1", done1, n_done);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    @(posedge clk);
    #1 bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    collect(1'b1, 1, 3354);
    bus_b.start = 1'b0;
    collect(1'b1, 3355, 5);
    tests++;
    if (n_done != 2 || done2 - done1 != 1677) begin
      fails++; $display("FAIL b2b_done_spacing: got count %0d spacing %0d expected 2/1677", n_done, done2 - done1);
    end
    tests++;
    if (n_overlap != 0 || busy_err != 0 || n_reset != 2) begin
      fails++; $display("FAIL b2b_strobes: got overlap=%0d busy_err=%0d inits=%0d expected 0/0/2", n_overlap, busy_err, n_reset);
    end
  endtask

  initial begin
    test_reset();
    test_small_encode();
    test_full_encode();
    test_start_while_busy();
    test_reset_mid_encode();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
